serial_adder: RTL

//   Bit-serial adder. It computes (a + b + cin) over WIDTH clock cycles, LSB first,

---
 rtl/serial_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: (a + b + cin) computed LSB first over WIDTH cycles with one full-adder
// cell and a registered carry, framed by valid/ready handshakes on input and output.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bit_sum, bit_carry;
  logic [WIDTH-1:0] sum_shifted;

  always_comb begin
    bit_sum     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    bit_carry   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    sum_shifted = (sum_sh_q >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        carry_d  = bit_carry;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shifted;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Visible result is updated only here so it holds across DONE and IDLE.
          sum_d   = sum_shifted;
          cout_d  = bit_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q != StIdle);

endmodule
